// File: rtl/branch_predictor.sv
// IF-stage branch predictor: 2-bit saturating-counter BHT plus direct-mapped BTB, trained from EX.
// Define BPU_GSHARE_EN to XOR a global history register into the BHT index (gshare).
module branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int GHR_W   = 6
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_if_pc,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target,
    input  logic        i_ex_valid,
    input  logic        i_ex_is_branch,
    input  logic [31:0] i_ex_pc,
    input  logic        i_ex_taken,
    input  logic [31:0] i_ex_target
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;

    function automatic logic [1:0] sat_inc(input logic [1:0] cnt);
        return (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] cnt);
        return (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    endfunction

    // A freshly allocated entry starts weakly biased toward its first outcome.
    function automatic logic [1:0] next_cnt(input logic hit, input logic taken,
                                             input logic [1:0] cnt);
        if (!hit)
            return taken ? 2'b10 : 2'b01;
        return taken ? sat_inc(cnt) : sat_dec(cnt);
    endfunction

    logic [ENTRIES-1:0] r_btb_valid;
    logic [TAG_W-1:0]   r_btb_tag [ENTRIES];
    logic [29:0]        r_btb_tgt [ENTRIES];
    logic [1:0]         r_bht_cnt [ENTRIES];

    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_if_cidx;
    logic [TAG_W-1:0] w_if_tag;
    logic             w_if_hit;

    logic [IDX_W-1:0] w_ex_idx;
    logic [IDX_W-1:0] w_ex_cidx;
    logic [TAG_W-1:0] w_ex_tag;
    logic             w_ex_hit;
    logic             w_upd;

    logic             w_unused_pc_lsbs;

    assign w_if_idx = i_if_pc[IDX_W+1:2];
    assign w_if_tag = i_if_pc[31:IDX_W+2];
    assign w_ex_idx = i_ex_pc[IDX_W+1:2];
    assign w_ex_tag = i_ex_pc[31:IDX_W+2];
    assign w_upd    = i_ex_valid && i_ex_is_branch;

    assign w_unused_pc_lsbs = ^{i_if_pc[1:0], i_ex_pc[1:0], i_ex_target[1:0]};

`ifdef BPU_GSHARE_EN
    logic [GHR_W-1:0] r_ghr;

    // The BHT write on this edge indexes with the pre-shift history.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_ghr <= '0;
        else if (w_upd)
            r_ghr <= (r_ghr << 1) | GHR_W'(i_ex_taken);
    end

    assign w_if_cidx = w_if_idx ^ IDX_W'(r_ghr);
    assign w_ex_cidx = w_ex_idx ^ IDX_W'(r_ghr);
`else
    assign w_if_cidx = w_if_idx;
    assign w_ex_cidx = w_ex_idx;
`endif

    // Predict reads pre-update state; a same-cycle write shows up next cycle.
    assign w_if_hit      = r_btb_valid[w_if_idx] && (r_btb_tag[w_if_idx] == w_if_tag);
    assign o_pred_taken  = w_if_hit && r_bht_cnt[w_if_cidx][1];
    assign o_pred_target = w_if_hit ? {r_btb_tgt[w_if_idx], 2'b00} : 32'h0;

    assign w_ex_hit = r_btb_valid[w_ex_idx] && (r_btb_tag[w_ex_idx] == w_ex_tag);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_btb_valid <= '0;
            for (int i = 0; i < ENTRIES; i++)
                r_bht_cnt[i] <= 2'b01;
        end else if (w_upd) begin
            r_btb_valid[w_ex_idx] <= 1'b1;
            r_bht_cnt[w_ex_cidx]  <= next_cnt(w_ex_hit, i_ex_taken, r_bht_cnt[w_ex_cidx]);
        end
    end

    // Tag/target payload is meaningless while the valid bit is clear, so it carries no reset.
    always_ff @(posedge i_clk) begin
        if (w_upd) begin
            r_btb_tag[w_ex_idx] <= w_ex_tag;
            if (!w_ex_hit || i_ex_taken)
                r_btb_tgt[w_ex_idx] <= i_ex_target[31:2];
        end
    end

endmodule
